// File: rtl/tdm_codec_if.sv
// tdm_codec_if
// ------------
// TDM serial-audio master for AK4619-class codecs. A single counter running
// on the sample clock generates BICK/MCLK/LRCK, shifts DAC words out on sdin1
// and assembles ADC words from sdout1. The interface free-runs frame to
// frame. A strobe only forces an early frame boundary.
//
// Parameters
//   W           sample width in bits (1 .. SLOT_BITS-I2S_DELAY)
//   N_CHANNELS  TDM slots per frame (2, 4 or 8)
//   SLOT_BITS   BICK periods per slot (16 or 32)
//   I2S_DELAY   1: slot MSB one BICK after slot start, 0: MSB-justified
//   FSYNC_PULSE 0: 50% duty LRCK, 1: LRCK high for the first BICK period
//
// Ports
//   clk_256fs     sample clock, 2*N_CHANNELS*SLOT_BITS*Fs
//   rst_n         synchronous active-low reset
//   strobe        one-cycle frame resync / latch request
//   pdn           codec power-down, follows rst_n
//   mclk, bick    bit clock (clk_256fs / 2)
//   lrck          frame sync
//   sdin1         serial DAC data to the codec (registered)
//   sdout1        serial ADC data from the codec
//   sample_in     DAC words, channel k at [k*W +: W]
//   sample_out    ADC words, same packing (two's complement, bit-exact)
//   sample_valid  one-cycle pulse when sample_out updates
//   sync_err      sticky flag: a strobe arrived off the frame boundary

module tdm_codec_if #(
    parameter int W           = 16,
    parameter int N_CHANNELS  = 4,
    parameter int SLOT_BITS   = 32,
    parameter int I2S_DELAY   = 0,
    parameter int FSYNC_PULSE = 0
) (
    input  logic                    clk_256fs,
    input  logic                    rst_n,
    input  logic                    strobe,
    output logic                    pdn,
    output logic                    mclk,
    output logic                    bick,
    output logic                    lrck,
    output logic                    sdin1,
    input  logic                    sdout1,
    input  logic [W*N_CHANNELS-1:0] sample_in,
    output logic [W*N_CHANNELS-1:0] sample_out,
    output logic                    sample_valid,
    output logic                    sync_err
);

    localparam int FRAME_BITS = N_CHANNELS * SLOT_BITS;
    localparam int CNT_W      = $clog2(2 * FRAME_BITS);
    localparam int POS_W      = $clog2(SLOT_BITS);
    localparam int SLOT_W     = $clog2(N_CHANNELS);

    // Frame length is a power of two, so the last count is all ones.
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Frame counter and serial-side registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              sdin1_reg, sdin1_next;
    logic              sample_valid_reg, sample_valid_next;
    logic              sync_err_reg, sync_err_next;

    // Counter field split: bit 0 is the BICK phase, then the bit position
    // inside the slot, then the slot number.
    logic [POS_W-1:0]  bit_pos;
    logic [SLOT_W-1:0] slot;
    logic              at_last;
    logic              latch_ev;

    // Data-bit decode for the current position
    int                data_idx;
    logic              is_data;
    logic [W-1:0]      bit_mask;
    logic              tx_bit;
    logic [W-1:0]      shadow_word;

    // Per-channel DAC shadow words gathered for the slot multiplexer
    logic [N_CHANNELS-1:0][W-1:0] shadow_bus;

    assign bit_pos  = cnt_reg[POS_W:1];
    assign slot     = cnt_reg[CNT_W-1:POS_W+1];
    assign at_last  = (cnt_reg == CNT_LAST);
    // A strobe and the natural frame end merge into one latch event.
    assign latch_ev = strobe || at_last;

    // Position decode: which sample bit (if any) lives at this BICK period.
    // bit_mask is one-hot on that bit and all-zero for padding positions,
    // so it doubles as the capture enable for the accumulators.
    always_comb begin
        data_idx    = int'(bit_pos) - I2S_DELAY;
        is_data     = (data_idx >= 0) && (data_idx < W);
        shadow_word = shadow_bus[slot];
        bit_mask    = '0;
        tx_bit      = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (is_data && (i == W - 1 - data_idx)) begin
                bit_mask[i] = 1'b1;
                tx_bit      = shadow_word[i];
            end
        end
    end

    // Next-state logic for the counter and the serial output
    always_comb begin
        cnt_next          = cnt_reg + 1'b1;
        sdin1_next        = sdin1_reg;
        sample_valid_next = 1'b0;
        sync_err_next     = sync_err_reg;
        if (latch_ev) begin
            cnt_next          = '0;
            sample_valid_next = 1'b1;
            // Position 0 of the next frame belongs to channel 0 of the word
            // being latched right now, so take it straight from sample_in.
            sdin1_next        = (I2S_DELAY == 0) ? sample_in[W-1] : 1'b0;
            if (strobe && !at_last) begin
                sync_err_next = 1'b1;
            end
        end else if (!cnt_reg[0]) begin
            // BICK about to rise: present the bit for this position.
            sdin1_next = tx_bit;
        end
    end

    always_ff @(posedge clk_256fs) begin
        if (!rst_n) begin
            cnt_reg          <= '0;
            sdin1_reg        <= 1'b0;
            sample_valid_reg <= 1'b0;
            sync_err_reg     <= 1'b0;
        end else begin
            cnt_reg          <= cnt_next;
            sdin1_reg        <= sdin1_next;
            sample_valid_reg <= sample_valid_next;
            sync_err_reg     <= sync_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel storage: DAC shadow, ADC accumulator, output word
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
            logic [W-1:0] shadow_reg;
            logic [W-1:0] acc_reg;
            logic [W-1:0] acc_next;
            logic [W-1:0] out_reg;
            logic         capture;

            // Capture on BICK high->low inside this channel's slot; the
            // latch cycle is excluded because it starts a new frame.
            assign capture  = !latch_ev && cnt_reg[0] && (slot == SLOT_W'(gi));
            assign acc_next = (acc_reg & ~bit_mask) | (sdout1 ? bit_mask : '0);

            always_ff @(posedge clk_256fs) begin
                if (!rst_n) begin
                    shadow_reg <= '0;
                    acc_reg    <= '0;
                    out_reg    <= '0;
                end else if (latch_ev) begin
                    shadow_reg <= sample_in[gi*W +: W];
                    out_reg    <= acc_reg;
                end else if (capture) begin
                    acc_reg    <= acc_next;
                end
            end

            assign shadow_bus[gi]         = shadow_reg;
            assign sample_out[gi*W +: W]  = out_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Clock and frame-sync outputs
    // ------------------------------------------------------------------
    assign pdn          = rst_n;
    assign bick         = cnt_reg[0];
    assign mclk         = cnt_reg[0];
    assign sdin1        = sdin1_reg;
    assign sample_valid = sample_valid_reg;
    assign sync_err     = sync_err_reg;

    generate
        if (FSYNC_PULSE != 0) begin : g_lrck_pulse
            // High only for the first BICK period of the frame (cnt 0..1).
            assign lrck = (cnt_reg[CNT_W-1:1] == '0);
        end else begin : g_lrck_half
            assign lrck = cnt_reg[CNT_W-1];
        end
    endgenerate

endmodule

// File: tb/tb_tdm_codec_if.sv
// Bench for tdm_codec_if: three instances in different configurations,
// checked every cycle against a frame-level reference model.
//   A: defaults, sdout1 looped back to sdin1
//   B: I2S_DELAY=1, random sdout1, ch0 = 0xC000
//   C: W=24, N_CHANNELS=8, FSYNC_PULSE=1, sdout1 = 1
`timescale 1ns/1ps
module tb_tdm_codec_if;

    localparam int PW  [3] = '{16, 16, 24};
    localparam int PN  [3] = '{4, 4, 8};
    localparam int PSB [3] = '{32, 32, 32};
    localparam int PD  [3] = '{0, 1, 0};
    localparam int PFP [3] = '{0, 0, 1};

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n_v;
    logic         strb [3];
    logic         pdn_w [3], mclk_w [3], bick_w [3], lrck_w [3];
    logic         sdin_w [3], valid_w [3], err_w [3];
    logic         sdo_b, sdo_c;
    logic [63:0]  sin_a, sin_b, so_a, so_b;
    logic [191:0] sin_c, so_c;

    tdm_codec_if #(.W(16), .N_CHANNELS(4), .SLOT_BITS(32), .I2S_DELAY(0), .FSYNC_PULSE(0)) dut_a (
        .clk_256fs(clk), .rst_n(rst_n_v), .strobe(strb[0]), .pdn(pdn_w[0]), .mclk(mclk_w[0]),
        .bick(bick_w[0]), .lrck(lrck_w[0]), .sdin1(sdin_w[0]), .sdout1(sdin_w[0]),
        .sample_in(sin_a), .sample_out(so_a), .sample_valid(valid_w[0]), .sync_err(err_w[0]));

    tdm_codec_if #(.W(16), .N_CHANNELS(4), .SLOT_BITS(32), .I2S_DELAY(1), .FSYNC_PULSE(0)) dut_b (
        .clk_256fs(clk), .rst_n(rst_n_v), .strobe(strb[1]), .pdn(pdn_w[1]), .mclk(mclk_w[1]),
        .bick(bick_w[1]), .lrck(lrck_w[1]), .sdin1(sdin_w[1]), .sdout1(sdo_b),
        .sample_in(sin_b), .sample_out(so_b), .sample_valid(valid_w[1]), .sync_err(err_w[1]));

    tdm_codec_if #(.W(24), .N_CHANNELS(8), .SLOT_BITS(32), .I2S_DELAY(0), .FSYNC_PULSE(1)) dut_c (
        .clk_256fs(clk), .rst_n(rst_n_v), .strobe(strb[2]), .pdn(pdn_w[2]), .mclk(mclk_w[2]),
        .bick(bick_w[2]), .lrck(lrck_w[2]), .sdin1(sdin_w[2]), .sdout1(sdo_c),
        .sample_in(sin_c), .sample_out(so_c), .sample_valid(valid_w[2]), .sync_err(err_w[2]));

    // Reference model state (frame level)
    int          m_cnt [3];
    logic [23:0] m_shadow [3][8];
    logic [23:0] m_out [3][8];
    logic        m_valid [3];
    logic        m_err [3];
    logic        rx_bits [3][8][32];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag, input int id);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, id, obs, exp);
        end
    endtask

    function automatic logic [23:0] in_word(input int d, input int k);
        logic [23:0] w = '0;
        case (d)
            0: w = 24'(sin_a[k*16 +: 16]);
            1: w = 24'(sin_b[k*16 +: 16]);
            default: w = sin_c[k*24 +: 24];
        endcase
        return w;
    endfunction

    function automatic logic [23:0] out_word(input int d, input int k);
        logic [23:0] w = '0;
        case (d)
            0: w = 24'(so_a[k*16 +: 16]);
            1: w = 24'(so_b[k*16 +: 16]);
            default: w = so_c[k*24 +: 24];
        endcase
        return w;
    endfunction

    // Bit the codec should see on sdin1 while BICK is high at count c.
    function automatic logic exp_tx(input int d, input int c);
        int p, s, pos, b;
        logic [23:0] wd;
        p   = c / 2;
        s   = p / PSB[d];
        pos = p % PSB[d];
        b   = pos - PD[d];
        if (b < 0 || b >= PW[d]) return 1'b0;
        wd = m_shadow[d][s];
        return wd[PW[d] - 1 - b];
    endfunction

    // ADC word of slot s from the bits sampled at its data positions.
    function automatic logic [23:0] assemble(input int d, input int s);
        logic [23:0] w = '0;
        for (int b = 0; b < PW[d]; b++)
            if (rx_bits[d][s][b + PD[d]]) w = w | (24'd1 << (PW[d] - 1 - b));
        return w;
    endfunction

    function automatic logic sdo_model(input int d);
        if (d == 0) return exp_tx(0, m_cnt[0]);
        if (d == 1) return sdo_b;
        return sdo_c;
    endfunction

    // Apply the effect of the coming rising edge to the model.
    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            int last;
            last = 2 * PN[d] * PSB[d] - 1;
            if (!rst_n_v) begin
                m_cnt[d] = 0; m_valid[d] = 1'b0; m_err[d] = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    m_shadow[d][k] = '0; m_out[d][k] = '0;
                    for (int j = 0; j < 32; j++) rx_bits[d][k][j] = 1'b0;
                end
            end else if (strb[d] || m_cnt[d] == last) begin
                for (int k = 0; k < PN[d]; k++) begin
                    m_out[d][k]    = assemble(d, k);
                    m_shadow[d][k] = in_word(d, k);
                end
                if (strb[d] && m_cnt[d] != last) m_err[d] = 1'b1;
                m_valid[d] = 1'b1;
                m_cnt[d]   = 0;
            end else begin
                if (m_cnt[d] % 2 == 1) begin
                    int p, s, pos, b;
                    p   = m_cnt[d] / 2;
                    s   = p / PSB[d];
                    pos = p % PSB[d];
                    b   = pos - PD[d];
                    if (b >= 0 && b < PW[d]) rx_bits[d][s][pos] = sdo_model(d);
                end
                m_valid[d] = 1'b0;
                m_cnt[d]++;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            int   c;
            logic e_lr;
            c    = m_cnt[d];
            e_lr = (PFP[d] == 1) ? (c < 2) : (c >= PN[d] * PSB[d]);
            chk(pdn_w[d], rst_n_v, "pdn", d);
            chk(bick_w[d], c % 2, "bick", d);
            chk(mclk_w[d], c % 2, "mclk", d);
            chk(lrck_w[d], e_lr, "lrck", d);
            chk(valid_w[d], m_valid[d], "sample_valid", d);
            chk(err_w[d], m_err[d], "sync_err", d);
            if (c % 2 == 1) chk(sdin_w[d], exp_tx(d, c), "sdin1", d);
            for (int k = 0; k < PN[d]; k++) chk(out_word(d, k), m_out[d][k], "sample_out", d * 8 + k);
        end
    endtask

    task automatic tick();
        sdo_b = 1'($urandom_range(0, 1));
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_inputs();
        sin_b[63:16] = {16'($urandom), 16'($urandom), 16'($urandom)};
        for (int k = 0; k < 8; k++) sin_c[k*24 +: 24] = 24'($urandom);
    endtask

    int pulses_a = 0;
    int pulses_b = 0;
    int n_pulse  = 0;
    int target   = 0;

    initial begin
        rst_n_v = 1'b0;
        strb[0] = 1'b0; strb[1] = 1'b0; strb[2] = 1'b0;
        sdo_b = 1'b0; sdo_c = 1'b1;
        sin_a = {16'hA5A5, 16'h7FFF, 16'h1234, 16'h8001};
        sin_b = 64'h0000_0000_0000_C000;
        sin_c = '0;
        rand_inputs();
        @(negedge clk);
        repeat (3) tick();
        rst_n_v = 1'b1;

        // Free-running frames
        for (int i = 0; i < 1100; i++) begin
            if (i % 97 == 0) rand_inputs();
            tick();
            if (m_valid[0]) begin
                pulses_a++;
                if (pulses_a >= 3)
                    for (int k = 0; k < 4; k++) chk(out_word(0, k), in_word(0, k), "loopback", k);
            end
            if (m_valid[1]) pulses_b++;
            if (pulses_b >= 1 && (m_cnt[1] == 1 || m_cnt[1] == 3 || m_cnt[1] == 5 || m_cnt[1] == 7))
                chk(sdin_w[1], (m_cnt[1] == 3 || m_cnt[1] == 5), "i2s_ch0_bits", m_cnt[1]);
            if (m_valid[2])
                for (int k = 0; k < 8; k++) chk(out_word(2, k), 24'hFFFFFF, "adc_all_ones", k);
            if (m_cnt[2] % 2 == 1 && (m_cnt[2] / 2) % 32 >= 24)
                chk(sdin_w[2], 1'b0, "pad_bits_zero", m_cnt[2]);
        end

        // Resync A mid-frame at cnt 100
        for (int i = 0; i < 600 && m_cnt[0] != 100; i++) tick();
        strb[0] = 1'b1;
        tick();
        strb[0] = 1'b0;
        chk(err_w[0], 1'b1, "sync_err_set", 0);
        chk(bick_w[0], 1'b0, "resync_cnt0", 0);
        n_pulse = int'(valid_w[0]);
        for (int i = 0; i < 9; i++) begin
            tick();
            n_pulse += int'(valid_w[0]);
        end
        chk(n_pulse, 1, "single_pulse", 0);

        // Random mid-frame strobe on B, on-boundary strobe on C
        target = $urandom_range(20, 200);
        for (int i = 0; i < 600 && m_cnt[1] != target; i++) tick();
        strb[1] = 1'b1;
        tick();
        strb[1] = 1'b0;
        for (int i = 0; i < 1100 && m_cnt[2] != 511; i++) tick();
        strb[2] = 1'b1;
        tick();
        strb[2] = 1'b0;
        chk(err_w[2], 1'b0, "boundary_strobe_c", 2);
        chk(valid_w[2], 1'b1, "boundary_pulse_c", 2);
        for (int i = 0; i < 300; i++) begin
            if (i % 53 == 0) rand_inputs();
            tick();
        end

        // One-cycle reset at A cnt 77, then boundary strobe at 255
        for (int i = 0; i < 600 && m_cnt[0] != 77; i++) tick();
        rst_n_v = 1'b0;
        #1;
        chk(pdn_w[0], 1'b0, "pdn_low", 0);
        tick();
        rst_n_v = 1'b1;
        chk(so_a, 64'd0, "reset_sample_out", 0);
        chk(err_w[0], 1'b0, "reset_sync_err", 0);
        chk(sdin_w[0], 1'b0, "reset_sdin1", 0);
        for (int i = 0; i < 600 && m_cnt[0] != 255; i++) tick();
        strb[0] = 1'b1;
        tick();
        strb[0] = 1'b0;
        chk(err_w[0], 1'b0, "boundary_strobe_a", 0);
        chk(valid_w[0], 1'b1, "boundary_pulse_a", 0);
        for (int i = 0; i < 800; i++) begin
            if (i % 71 == 0) rand_inputs();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tdm_codec_if.md
Name: tdm_codec_if

Overview:
- Parametrised TDM serial-audio master for AK4619-class codecs. Generalises channel count, sample width, slot width, frame-sync style and data delay.
- Generates MCLK/BICK/LRCK from the single sample-rate clock and free-runs frame to frame; an external strobe only resynchronises it.
- Sits between the I2C-configured codec pins and the sample-domain DSP; the I2C master selects the matching codec mode.

Parameters:
- W, 16, sample width in bits; 1 <= W <= SLOT_BITS - I2S_DELAY.
- N_CHANNELS, 4, TDM slots per frame; one of 2, 4, 8.
- SLOT_BITS, 32, BICK periods per slot; 16 or 32.
- I2S_DELAY, 0, 1 = slot MSB one BICK after slot start (I2S style); 0 = MSB-justified.
- FSYNC_PULSE, 0, 0 = 50% duty LRCK; 1 = LRCK high for one BICK period at frame start.

Ports:
- clk_256fs  in  1  sample clock = 2*N_CHANNELS*SLOT_BITS*Fs (256Fs at defaults).
- rst_n  in  1  synchronous, active-low reset.
- strobe  in  1  optional frame resync / latch request, one cycle.
- pdn  out  1  codec power-down = rst_n (combinational).
- mclk  out  1  = bick.
- bick  out  1  = counter[0].
- lrck  out  1  frame sync, see Behaviour.
- sdin1  out  1  serial DAC data to codec (registered).
- sdout1  in  1  serial ADC data from codec.
- sample_in  in  W*N_CHANNELS  DAC words; channel k at [k*W +: W].
- sample_out  out  W*N_CHANNELS  ADC words, same packing, signed.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- sync_err  out  1  sticky: a strobe arrived off frame boundary.

Behaviour:
- FRAME_BITS = N_CHANNELS*SLOT_BITS. Counter cnt has log2(2*FRAME_BITS) bits and counts 0..2*FRAME_BITS-1. LAST is the top value.
- Field split of cnt: bit 0 = BICK phase; bit_pos = cnt[log2(SLOT_BITS):1]; slot = upper bits. Data index b = bit_pos - I2S_DELAY. A position is a data bit when 0 <= b < W.
- Reset (rst_n low at posedge): cnt=0, sdin1=0, sample_out=0, sample_valid=0, sync_err=0, DAC shadow=0, ADC accumulators=0. Reset takes priority over everything. Mid-frame reset abandons the frame; the next frame starts at cnt=0.
- Latch event (L): occurs in any cycle with strobe=1, or with cnt==LAST. On L:
  - cnt <= 0.
  - DAC shadow <= sample_in.
  - sample_out <= ADC accumulators.
  - sample_valid <= 1 on the next cycle only.
  - sdin1 <= shadow slot-0 bit for position 0: the MSB of the new sample_in ch0 if I2S_DELAY=0, else 0.
- strobe with cnt==LAST produces a single L and leaves sync_err unchanged. strobe with cnt!=LAST resyncs and sets sync_err=1 until reset.
- Non-L cycles with bick=1 (BICK high->low): if b is a data bit, accumulator[slot][W-1-b] <= sdout1. Non-data positions are ignored. cnt++.
- Non-L cycles with bick=0 (BICK low->high): sdin1 <= shadow[slot][W-1-b] for the position being entered if data, else 0. cnt++.
- lrck, FSYNC_PULSE=0: MSB of cnt (low for first half-frame).
- lrck, FSYNC_PULSE=1: high iff cnt < 2.
- Latency: a DAC sample is latched at L and appears on the wire in the following frame. An ADC sample captured in frame n appears on sample_out at the L ending frame n. Loopback latency from sample_in to sample_out is one frame.
- Signedness: words pass through bit-exact; no scaling.

Test Plan:
- Defaults, sdout1 tied to sdin1, sample_in ch0..3 = 0x8001, 0x1234, 0x7FFF, 0xA5A5 held -> sample_valid pulses every 256 clocks; from the third pulse sample_out equals sample_in; sync_err=0.
- I2S_DELAY=1, ch0=0xC000 -> sdin1 is 0 in BICK period 0, 1 in periods 1-2, then 0. lrck low for cnt 0..127 and high for 128..255.
- N_CHANNELS=8, FSYNC_PULSE=1 -> frame is 512 clocks; lrck high exactly 2 clocks per frame, at cnt 0-1.
- Strobe at cnt=100 -> cnt=0 next cycle, sync_err=1, a single sample_valid pulse. Strobe at cnt=255 after reset -> one pulse, sync_err stays 0.
- W=24, SLOT_BITS=32, sdout1=1 constantly -> sample_out words = 0xFFFFFF; sdin1 is 0 during BICK periods 24-31 of every slot.
- rst_n low for 1 cycle at cnt=77 -> next cycle: all outputs 0, pdn=0 during reset, frame restarts at cnt=0.
